// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory-access pipeline stage: pipeline payloads,
// forwarding status, FSM states and access-width encodings.
package memory_access_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

  typedef enum logic [1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10
  } memory_mask_t;

  typedef enum logic {ZERO_EXTEND = 1'b0, SIGN_EXTEND = 1'b1} memory_sign_extension_t;

  typedef struct packed {
    logic [4:0]  address;
    logic        valid;
    logic [31:0] data;
  } forwarding_data_status_t;

  typedef struct packed {
    logic                    valid;
    logic [31:0]             pc;
    logic [31:0]             instruction;
    forwarding_data_status_t data;
    logic [31:0]             reg_rd2;
    logic                    reg_we;
    logic                    mem_read;
    logic                    mem_write;
    memory_mask_t            mem_mask;
    memory_sign_extension_t  mem_sign_ext;
  } stage_status_t;

  // Half accesses need even addresses, words need 4-byte alignment.
  function automatic logic access_misaligned(logic [1:0] addr_lsb, memory_mask_t mask);
    case (mask)
      MASK_BYTE: return 1'b0;
      MASK_HALF: return addr_lsb[0];
      default:   return addr_lsb != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory bus: request/ready handshake plus a separate read-response strobe.
interface memory_access_stage_if;
  import memory_access_stage_pkg::*;

  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/memory_access_stage_aligner.sv
// Combinational byte-lane logic: enables, store-data replication and
// load-data lane selection with sign/zero extension.
module load_store_aligner
  import memory_access_stage_pkg::*;
(
  input  logic [1:0]             addr_lsb,
  input  memory_mask_t           mask,
  input  memory_sign_extension_t sign_ext,
  input  logic [31:0]            wdata,
  input  logic [31:0]            rdata,
  output logic [3:0]             be,
  output logic [31:0]            wdata_lanes,
  output logic [31:0]            rdata_extended,
  output logic                   misaligned
);

  logic [31:0] rdata_shifted;
  logic        sign_on;

  assign rdata_shifted = rdata >> {addr_lsb, 3'b000};
  assign sign_on       = (sign_ext == SIGN_EXTEND);
  assign misaligned    = access_misaligned(addr_lsb, mask);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_lanes[8*gi +: 8] = (mask == MASK_BYTE) ? wdata[7:0] :
                                    (mask == MASK_HALF) ? wdata[8*(gi%2) +: 8] :
                                                          wdata[8*gi +: 8];
  end

  always_comb begin
    be             = 4'hF;
    rdata_extended = rdata;
    case (mask)
      MASK_BYTE: begin
        be             = 4'b0001 << addr_lsb;
        rdata_extended = {{24{sign_on & rdata_shifted[7]}}, rdata_shifted[7:0]};
      end
      MASK_HALF: begin
        be             = 4'b0011 << addr_lsb;
        rdata_extended = {{16{sign_on & rdata_shifted[15]}}, rdata_shifted[15:0]};
      end
      default: begin
        be             = 4'hF;
        rdata_extended = rdata;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: one-instruction slot driving the data bus,
// publishing forwarding status to decode and results to writeback.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  stage_status_t           stage_in,
  output logic                    stage_in_ready,
  output stage_status_t           stage_out,
  input  logic                    wb_ready,
  output forwarding_data_status_t fwd_status,
  memory_access_stage_if.master   mem,
  output logic                    misaligned
);

  mem_state_t    state_reg, state_next;
  stage_status_t slot_reg;
  logic          misaligned_reg;

  logic                    capture;
  logic                    in_mem_op;
  logic                    in_misaligned;
  mem_state_t              capture_state;
  logic                    slot_valid;
  logic [DATA_WIDTH/8-1:0] be_al;
  logic [DATA_WIDTH-1:0]   wdata_al;
  logic [DATA_WIDTH-1:0]   rdata_ext;
  logic                    misaligned_unused;

  load_store_aligner u_aligner (
    .addr_lsb       (slot_reg.data.data[1:0]),
    .mask           (slot_reg.mem_mask),
    .sign_ext       (slot_reg.mem_sign_ext),
    .wdata          (slot_reg.reg_rd2),
    .rdata          (mem.mem_rdata),
    .be             (be_al),
    .wdata_lanes    (wdata_al),
    .rdata_extended (rdata_ext),
    .misaligned     (misaligned_unused)
  );

  assign in_mem_op     = stage_in.mem_read | stage_in.mem_write;
  assign in_misaligned = in_mem_op && access_misaligned(stage_in.data.data[1:0], stage_in.mem_mask);
  assign capture_state = (in_mem_op && !in_misaligned) ? REQ : DONE;
  assign slot_valid    = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    stage_in_ready = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && wb_ready));
    capture        = stage_in.valid && stage_in_ready;
    mem.mem_req    = (state_reg == REQ);
    mem.mem_we     = (state_reg == REQ) && slot_reg.mem_write && !slot_reg.mem_read;
    mem.mem_addr   = (state_reg == REQ) ? {slot_reg.data.data[31:2], 2'b00} : '0;
    mem.mem_be     = (state_reg == REQ) ? be_al : '0;
    mem.mem_wdata  = (state_reg == REQ) ? wdata_al : '0;
    case (state_reg)
      IDLE: if (capture) state_next = capture_state;
      REQ:  if (mem.mem_ready) state_next = slot_reg.mem_read ? WAIT : DONE;
      WAIT: if (mem.mem_rvalid) state_next = DONE;
      DONE: if (wb_ready) state_next = capture ? capture_state : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Misaligned accesses never write the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg       <= '0;
      misaligned_reg <= 1'b0;
    end else if (capture) begin
      slot_reg        <= stage_in;
      slot_reg.reg_we <= stage_in.reg_we && !in_misaligned;
      misaligned_reg  <= in_misaligned;
    end else if ((state_reg == WAIT) && mem.mem_rvalid) begin
      slot_reg.data.data <= rdata_ext;
    end
  end

  always_comb begin
    fwd_status         = '0;
    fwd_status.address = (slot_valid && slot_reg.reg_we && !misaligned_reg) ? slot_reg.data.address : 5'd0;
    fwd_status.valid   = (state_reg == DONE);
    fwd_status.data    = slot_valid ? slot_reg.data.data : '0;
    stage_out          = slot_valid ? slot_reg : '0;
    stage_out.valid    = (state_reg == DONE);
    stage_out.data     = fwd_status;
    misaligned         = (state_reg == DONE) && misaligned_reg;
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized self-checking bench for memory_access_stage with a behavioural
// memory/pipeline reference model and a few directed scenarios.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stage_status_t           stage_in;
  stage_status_t           stage_out;
  logic                    stage_in_ready;
  logic                    wb_ready;
  logic                    misaligned;
  forwarding_data_status_t fwd_status;

  memory_access_stage_if bus ();

  memory_access_stage #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stage_in       (stage_in),
    .stage_in_ready (stage_in_ready),
    .stage_out      (stage_out),
    .wb_ready       (wb_ready),
    .fwd_status     (fwd_status),
    .mem            (bus.master),
    .misaligned     (misaligned)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    stage_status_t s;
    int rdy_dly;
    int rsp_dly;
    int wb_stall;
    int gap;
  } tx_t;

  typedef struct {
    stage_status_t s;
    logic [31:0] res;
    logic [4:0]  rd;
    bit mem_op, load, mis, accepted, done;
    int size, rdy_dly, rsp_dly, wb_stall;
  } exp_t;

  tx_t         stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] memory [0:255];

  function automatic int size_of(memory_mask_t m);
    case (m)
      MASK_BYTE: return 1;
      MASK_HALF: return 2;
      default:   return 4;
    endcase
  endfunction

  function automatic stage_status_t mk(int kind, int rd, logic [31:0] res, logic [31:0] wd,
                                       int mask, bit sext, bit we, logic [31:0] pc);
    stage_status_t s;
    s = '0;
    s.valid        = 1'b1;
    s.pc           = pc;
    s.instruction  = $urandom;
    s.data.address = rd[4:0];
    s.data.data    = res;
    s.reg_rd2      = wd;
    s.reg_we       = we;
    s.mem_read     = (kind == 1);
    s.mem_write    = (kind == 2);
    s.mem_mask     = memory_mask_t'(mask[1:0]);
    s.mem_sign_ext = sext ? SIGN_EXTEND : ZERO_EXTEND;
    return s;
  endfunction

  function automatic exp_t to_exp(tx_t t);
    exp_t e;
    e.s        = t.s;
    e.res      = t.s.data.data;
    e.mem_op   = t.s.mem_read || t.s.mem_write;
    e.load     = t.s.mem_read;
    e.size     = size_of(t.s.mem_mask);
    e.mis      = e.mem_op && ((t.s.data.data % e.size) != 0);
    e.rd       = (t.s.reg_we && !e.mis) ? t.s.data.address : 5'd0;
    e.accepted = 1'b0;
    e.done     = !e.mem_op || e.mis;
    e.rdy_dly  = t.rdy_dly;
    e.rsp_dly  = t.rsp_dly;
    e.wb_stall = t.wb_stall;
    return e;
  endfunction

  function automatic logic [31:0] load_value(logic [31:0] a, int size, bit sext);
    logic [63:0] v, m;
    v = {32'b0, memory[a[9:2]]} >> (8 * (a % 4));
    m = (64'd1 << (8 * size)) - 1;
    v = v & m;
    if (sext && v[8*size-1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic store_bytes(logic [31:0] a, int size, logic [31:0] d);
    logic [31:0] b;
    for (int k = 0; k < size; k++) begin
      b = a + k;
      memory[b[9:2]][{b[1:0], 3'b000} +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic add(stage_status_t s, int rdy, int rsp, int wbs, int gap);
    tx_t t;
    t.s = s; t.rdy_dly = rdy; t.rsp_dly = rsp; t.wb_stall = wbs; t.gap = gap;
    stim_q.push_back(t);
  endtask

  task automatic run_model(int max_cycles);
    bit   cur_valid = 0;
    tx_t  cur;
    bit   exp_out, exp_req, exp_rdy, accept, resp, handoff;
    logic [31:0] ew, ewd, eaddr;
    logic [3:0]  ebe;
    int   cycles = 0;
    exp_t h;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || cur_valid) && cycles < max_cycles) begin
      cycles++;
      if (!cur_valid && stim_q.size() > 0) begin
        if (stim_q[0].gap > 0) stim_q[0].gap = stim_q[0].gap - 1;
        else begin cur = stim_q.pop_front(); cur_valid = 1; end
      end
      stage_in = cur_valid ? cur.s : '0;
      exp_out = 0; exp_req = 0; accept = 0; resp = 0;
      wb_ready = $urandom_range(0, 1);
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        exp_out = h.done;
        exp_req = h.mem_op && !h.mis && !h.accepted;
        if (h.done) begin
          wb_ready = (h.wb_stall == 0);
          if (h.wb_stall > 0) exp_q[0].wb_stall = h.wb_stall - 1;
        end else if (exp_req) begin
          bus.mem_ready = (h.rdy_dly == 0);
          accept = (h.rdy_dly == 0);
          if (h.rdy_dly > 0) exp_q[0].rdy_dly = h.rdy_dly - 1;
        end else begin
          bus.mem_rvalid = (h.rsp_dly == 0);
          resp = (h.rsp_dly == 0);
          if (resp) bus.mem_rdata = memory[h.res[9:2]];
          else exp_q[0].rsp_dly = h.rsp_dly - 1;
        end
      end
      #1;
      exp_rdy = (exp_q.size() == 0) || (exp_out && wb_ready);
      check("out_valid", stage_out.valid, exp_out);
      check("in_ready", stage_in_ready, exp_rdy);
      check("mem_req", bus.mem_req, exp_req);
      check("fwd_valid", fwd_status.valid, exp_out);
      check("fwd_addr", fwd_status.address, (exp_q.size() > 0) ? h.rd : 5'd0);
      if (exp_req) begin
        eaddr = h.res & ~32'd3;
        ebe   = 4'(((1 << h.size) - 1) << (h.res % 4));
        ewd   = h.s.reg_rd2;
        for (int k = 0; k < 4; k++) ew[8*k +: 8] = ewd[8*(k % h.size) +: 8];
        check("mem_addr", bus.mem_addr, eaddr);
        check("mem_be", bus.mem_be, ebe);
        check("mem_we", bus.mem_we, !h.load);
        if (!h.load) check("mem_wdata", bus.mem_wdata, ew);
      end
      handoff = exp_out && wb_ready;
      if (exp_out) begin
        check("fwd_data", fwd_status.data, h.res);
        check("misaligned", misaligned, h.mis);
      end
      if (handoff) begin
        check("out_pc", stage_out.pc, h.s.pc);
        check("out_data", stage_out.data.data, h.res);
        check("out_rd", stage_out.data.address, h.rd);
        $display("[TB] tx pc=%08h ld=%0d st=%0d mis=%0d rd=%0d data=%08h",
                 h.s.pc, h.load, h.s.mem_write, h.mis, h.rd, h.res);
        void'(exp_q.pop_front());
      end else if (accept) begin
        exp_q[0].accepted = 1'b1;
        if (!h.load) begin
          store_bytes(h.res, h.size, h.s.reg_rd2);
          exp_q[0].done = 1'b1;
        end
      end else if (resp) begin
        exp_q[0].res  = load_value(h.res, h.size, h.s.mem_sign_ext == SIGN_EXTEND);
        exp_q[0].done = 1'b1;
      end
      if (cur_valid && exp_rdy) begin
        exp_q.push_back(to_exp(cur));
        cur_valid = 0;
      end
      @(posedge clk); #1;
    end
    check("drain_timeout", cycles < max_cycles, 1'b1);
    stage_in = '0;
  endtask

  task automatic check_all_zero(string tag, bit exp_ready);
    check({tag, "_in_ready"}, stage_in_ready, exp_ready);
    check({tag, "_out_valid"}, stage_out.valid, 1'b0);
    check({tag, "_out_pc"}, stage_out.pc, 32'd0);
    check({tag, "_fwd"}, fwd_status, '0);
    check({tag, "_mem_req"}, bus.mem_req, 1'b0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_be"}, bus.mem_be, 4'd0);
    check({tag, "_misaligned"}, misaligned, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memory[i] = $urandom;
    memory[8'h40] = 32'h80FF_FFFF;
    stage_in = '0;
    wb_ready = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset", 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    add(mk(0, 5, 32'h1234, 0, 0, 0, 1, 32'h100), 0, 0, 0, 0);
    add(mk(1, 6, 32'h103, 0, 0, 1, 1, 32'h104), 0, 0, 0, 0);
    add(mk(1, 6, 32'h103, 0, 0, 0, 1, 32'h108), 0, 0, 0, 0);
    add(mk(2, 7, 32'h202, 32'hABCD, 1, 0, 0, 32'h10C), 3, 0, 0, 0);
    add(mk(1, 8, 32'h6, 0, 2, 0, 1, 32'h110), 0, 0, 0, 0);
    add(mk(0, 9, 32'hCAFE, 0, 0, 0, 1, 32'h114), 0, 0, 2, 0);
    add(mk(0, 10, 32'hBEEF, 0, 0, 0, 1, 32'h118), 0, 0, 0, 0);
    add(mk(0, 0, 32'h55, 0, 0, 0, 1, 32'h11C), 0, 0, 0, 0);
    run_model(200);

    for (int i = 0; i < 300; i++) begin
      int kind = $urandom_range(0, 2);
      logic [31:0] res = (kind == 0) ? $urandom : $urandom_range(0, 1023);
      add(mk(kind, $urandom_range(0, 31), res, $urandom, $urandom_range(0, 2), $urandom_range(0, 1),
             (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 32'h1000 + 4 * i),
          $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    run_model(20000);

    // Reset while a load is waiting for its response; the late reply must be dropped.
    wb_ready = 1'b1;
    stage_in = mk(1, 7, 32'h40, 0, 2, 0, 1, 32'h2000);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    stage_in = '0;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    #1;
    check("wait_fwd_addr", fwd_status.address, 5'd7);
    check("wait_fwd_valid", fwd_status.valid, 1'b0);
    check("wait_in_ready", stage_in_ready, 1'b0);
    rst_n = 1'b0;
    #1 check_all_zero("midreset", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check_all_zero("postreset", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
